// File: rtl/mat_vec_mul_ctrl.sv
// mat_vec_mul_ctrl: streams an N x N row-major matrix and an N-vector out of a
// dual-read-port RAM and writes y = A*x back into it.
// Optional feature macro: MAT_VEC_MUL_SAT_EN (saturating products and sums
// instead of modulo-2^32 arithmetic).
module mat_vec_mul_ctrl #(
    parameter int unsigned N      = 3,
    parameter int unsigned AW     = 5,
    parameter int unsigned A_BASE = 0,
    parameter int unsigned X_BASE = 9,
    parameter int unsigned Y_BASE = 12
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] raddr_0,
    input  logic [31:0]   rdata_0,
    output logic [AW-1:0] raddr_1,
    input  logic [31:0]   rdata_1,
    output logic [AW-1:0] waddr_0,
    output logic [31:0]   wdata_0,
    output logic          wen_0,
    output logic          valid
);

    localparam int unsigned NN = N * N;
    localparam int unsigned EW = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_SETTLE0,
        S_SETTLE1,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   e_q, e_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic            dv_q, dv_d;
    logic [CW-1:0]   dcol_q, dcol_d, drow_q, drow_d;
    logic [31:0]     acc_q, acc_d;
    logic [AW-1:0]   raddr_0_d, raddr_1_d, waddr_0_d;
    logic [31:0]     wdata_0_d;
    logic            wen_0_d, valid_d;
    logic [31:0]     prod_v, sum_v, beat_v;

    // Product of the current read beat and the running sum it extends
`ifdef MAT_VEC_MUL_SAT_EN
    logic [63:0] prod_full;
    logic [32:0] sum_full;
    always_comb begin
        prod_full = 64'(rdata_0) * 64'(rdata_1);
        prod_v    = (|prod_full[63:32]) ? 32'hFFFF_FFFF : prod_full[31:0];
        sum_full  = 33'(acc_q) + 33'(prod_v);
        sum_v     = sum_full[32] ? 32'hFFFF_FFFF : sum_full[31:0];
        beat_v    = (dcol_q == '0) ? prod_v : sum_v;
    end
`else
    always_comb begin
        prod_v = rdata_0 * rdata_1;
        sum_v  = acc_q + prod_v;
        beat_v = (dcol_q == '0) ? prod_v : sum_v;
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        col_d     = col_q;
        row_d     = row_q;
        dv_d      = 1'b0;
        dcol_d    = dcol_q;
        drow_d    = drow_q;
        acc_d     = acc_q;
        raddr_0_d = raddr_0;
        raddr_1_d = raddr_1;
        waddr_0_d = waddr_0;
        wdata_0_d = wdata_0;
        wen_0_d   = 1'b0;
        valid_d   = valid;

        // Data beat: read data of the element issued one cycle earlier
        if (dv_q) begin
            acc_d = beat_v;
            if (dcol_q == CW'(N - 1)) begin
                wen_0_d   = 1'b1;
                waddr_0_d = AW'(Y_BASE) + AW'(drow_q);
                wdata_0_d = beat_v;
            end
        end

        case (state_q)
            S_RUN: begin
                dv_d   = 1'b1;
                dcol_d = col_q;
                drow_d = row_q;
                if (e_q == EW'(NN - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    e_d = e_q + EW'(1);
                    if (col_q == CW'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    raddr_0_d = AW'(A_BASE) + AW'(e_d);
                    raddr_1_d = AW'(X_BASE) + AW'(col_d);
                end
            end
            S_DRAIN:   state_d = S_SETTLE0;
            S_SETTLE0: state_d = S_SETTLE1;
            S_SETTLE1: begin
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE:    state_d = S_DONE;
            default:   state_d = S_RUN;
        endcase
    end

    // State and output registers; reset presents element 0's addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            e_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            dv_q    <= 1'b0;
            dcol_q  <= '0;
            drow_q  <= '0;
            acc_q   <= '0;
            raddr_0 <= AW'(A_BASE);
            raddr_1 <= AW'(X_BASE);
            waddr_0 <= '0;
            wdata_0 <= '0;
            wen_0   <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dv_q    <= dv_d;
            dcol_q  <= dcol_d;
            drow_q  <= drow_d;
            acc_q   <= acc_d;
            raddr_0 <= raddr_0_d;
            raddr_1 <= raddr_1_d;
            waddr_0 <= waddr_0_d;
            wdata_0 <= wdata_0_d;
            wen_0   <= wen_0_d;
            valid   <= valid_d;
        end
    end

endmodule
